// File: rtl/dtree_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtree_pkg
// Brief    : Shared widths, node record, FSM states and node-packing helper
//            for the sequential decision-tree evaluator.
// Revision : 1.0 - initial release
// ============================================================================
package dtree_pkg;

    localparam int N_FEAT    = 7;
    localparam int FEAT_W    = 8;
    localparam int CLASS_W   = 5;
    localparam int N_NODES   = 32;
    localparam int MAX_DEPTH = 16;

    localparam int AW     = $clog2(N_NODES);
    localparam int FI_W   = $clog2(N_FEAT);
    localparam int SH_W   = $clog2(FEAT_W);
    localparam int DW     = $clog2(MAX_DEPTH + 1);
    localparam int NODE_W = 1 + FI_W + SH_W + FEAT_W + 2 * AW;

    localparam logic [CLASS_W-1:0] ERR_CLASS = '1;

    typedef struct packed {
        logic              is_leaf;
        logic [FI_W-1:0]   feat_idx;
        logic [SH_W-1:0]   shift;
        logic [FEAT_W-1:0] threshold;
        logic [AW-1:0]     left;
        logic [AW-1:0]     right;
    } node_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reset value of every table entry: a leaf reporting class 0.
    localparam node_t LEAF_ZERO = node_t'({1'b1, {(NODE_W-1){1'b0}}});

    function automatic node_t pack_node(
        input logic              leaf,
        input logic [FI_W-1:0]   fi,
        input logic [SH_W-1:0]   sh,
        input logic [FEAT_W-1:0] thr,
        input logic [AW-1:0]     l,
        input logic [AW-1:0]     r
    );
        node_t n;
        n.is_leaf   = leaf;
        n.feat_idx  = fi;
        n.shift     = sh;
        n.threshold = thr;
        n.left      = l;
        n.right     = r;
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtree_seq_eval_if.sv
`default_nettype none
// ============================================================================
// Module   : dtree_seq_eval_if
// Brief    : Feature-in / class-out handshakes and node-table config bus.
// Revision : 1.0 - initial release
// ============================================================================
interface dtree_seq_eval_if;
    import dtree_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] in_features;
    logic                     out_valid;
    logic                     out_ready;
    logic [CLASS_W-1:0]       out_class;
    logic [DW-1:0]            out_depth;
    logic                     out_err;
    logic                     cfg_we;
    logic [AW-1:0]            cfg_addr;
    logic [NODE_W-1:0]        cfg_wdata;
    logic                     cfg_err;

    modport master (
        output in_valid, in_features, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_class, out_depth, out_err, cfg_err
    );

    modport slave (
        input  in_valid, in_features, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_class, out_depth, out_err, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/dtree_node_table.sv
`default_nettype none
// ============================================================================
// Module   : dtree_node_table
// Brief    : N_NODES x NODE_W register file, one sync write, one async read.
// Revision : 1.0 - initial release
// ============================================================================
module dtree_node_table
    import dtree_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire node_t         wdata,
    input  wire logic [AW-1:0] raddr,
    output node_t              rdata
);

    node_t r_mem [N_NODES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) r_mem[i] <= LEAF_ZERO;
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/dtree_seq_eval.sv
`default_nettype none
// ============================================================================
// Module   : dtree_seq_eval
// Brief    : Sequential decision-tree classifier, one node comparison/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dtree_seq_eval
    import dtree_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    dtree_seq_eval_if.slave bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_ptr;
    logic [DW-1:0]      r_depth;
    logic [FEAT_W-1:0]  r_feat [N_FEAT];
    logic [CLASS_W-1:0] r_class;
    logic [DW-1:0]      r_out_depth;
    logic               r_err;
    logic               r_cfg_err;

    node_t              w_node;
    logic [FEAT_W-1:0]  w_sel;
    logic [FEAT_W-1:0]  w_opnd;
    logic               w_take;
    logic               w_accept;
    logic               w_leaf;
    logic               w_wdog;
    logic               w_step;
    logic               w_tbl_we;

    assign w_tbl_we = bus.cfg_we && (r_state == IDLE);

    dtree_node_table u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_tbl_we),
        .waddr (bus.cfg_addr),
        .wdata (node_t'(bus.cfg_wdata)),
        .raddr (r_ptr),
        .rdata (w_node)
    );

    // Out-of-range feature indices select a zero operand.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (int'(w_node.feat_idx) == i) w_sel = r_feat[i];
        end
    end

    // A logical shift by FEAT_W or more already yields zero.
    assign w_opnd = w_sel >> w_node.shift;
    assign w_take = (w_opnd <= w_node.threshold);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_leaf      = 1'b0;
        w_wdog      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WALK;
                end
            end
            WALK: begin
                if (w_node.is_leaf) begin
                    w_leaf      = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_depth == DW'(MAX_DEPTH)) begin
                    w_wdog      = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_depth     <= '0;
            r_class     <= '0;
            r_out_depth <= '0;
            r_err       <= 1'b0;
            r_cfg_err   <= 1'b0;
            for (int i = 0; i < N_FEAT; i++) r_feat[i] <= '0;
        end else begin
            r_cfg_err <= bus.cfg_we && (r_state != IDLE);
            if (w_accept) begin
                for (int i = 0; i < N_FEAT; i++)
                    r_feat[i] <= bus.in_features[i*FEAT_W +: FEAT_W];
                r_ptr   <= '0;
                r_depth <= '0;
            end
            if (w_step) begin
                r_ptr <= w_take ? w_node.left : w_node.right;
                if (r_depth != DW'(MAX_DEPTH)) r_depth <= r_depth + 1'b1;
            end
            if (w_leaf) begin
                r_class     <= w_node.threshold[CLASS_W-1:0];
                r_out_depth <= r_depth;
                r_err       <= 1'b0;
            end
            if (w_wdog) begin
                r_class     <= ERR_CLASS;
                r_out_depth <= DW'(MAX_DEPTH);
                r_err       <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_class = r_class;
    assign bus.out_depth = r_out_depth;
    assign bus.out_err   = r_err;
    assign bus.cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_dtree_seq_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtree_seq_eval
// Brief    : Self-checking bench for dtree_seq_eval with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtree_seq_eval;
    import dtree_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    typedef struct {
        logic [CLASS_W-1:0] cls;
        logic [DW-1:0]      depth;
        logic               err;
        int                 lat;
    } exp_t;

    exp_t sb[$];

    dtree_seq_eval_if bus ();

    dtree_seq_eval dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N_FEAT*FEAT_W-1:0] fv(input logic [7:0] x0,
                                                    input logic [7:0] x2,
                                                    input logic [7:0] x3);
        logic [N_FEAT*FEAT_W-1:0] v;
        v = '0;
        v[0*FEAT_W +: FEAT_W] = x0;
        v[2*FEAT_W +: FEAT_W] = x2;
        v[3*FEAT_W +: FEAT_W] = x3;
        return v;
    endfunction

    // Reference classification of the five-node test tree.
    function automatic exp_t model(input logic [7:0] x0, input logic [7:0] x2);
        exp_t e;
        e.err = 1'b0;
        if ((x2 >> 3) <= 8'd6) begin
            e.cls = 5'd19; e.depth = 5'd1; e.lat = 2;
        end else begin
            e.cls   = (x0 <= 8'd26) ? 5'd25 : 5'd31;
            e.depth = 5'd2; e.lat = 3;
        end
        return e;
    endfunction

    task automatic push_exp(input logic [CLASS_W-1:0] c, input logic [DW-1:0] d,
                            input logic er, input int lat);
        exp_t e;
        e.cls = c; e.depth = d; e.err = er; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input node_t n);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = n;
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL cfg_idle_err got=%b want=0", bus.cfg_err);
        end
    endtask

    task automatic drive_vec(input logic [N_FEAT*FEAT_W-1:0] v, output int waitc);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_features = v;
        waitc = 0;
        while (!bus.in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout got=0 want=1");
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input int hold);
        exp_t e;
        int   j;
        logic [CLASS_W-1:0] c0;
        j = 0;
        @(negedge clk);
        while (!bus.out_valid && j < 60) begin
            @(negedge clk);
            j++;
        end
        checks++;
        if (!bus.out_valid) begin
            failures++;
            $display("FAIL out_valid_timeout got=0 want=1");
        end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output class=%0d want=none", bus.out_class);
        end else begin
            e = sb.pop_front();
            if (bus.out_class !== e.cls) begin
                failures++;
                $display("FAIL out_class got=%0d want=%0d", bus.out_class, e.cls);
            end
            checks++;
            if (bus.out_depth !== e.depth) begin
                failures++;
                $display("FAIL out_depth got=%0d want=%0d", bus.out_depth, e.depth);
            end
            checks++;
            if (bus.out_err !== e.err) begin
                failures++;
                $display("FAIL out_err got=%b want=%b", bus.out_err, e.err);
            end
            checks++;
            if (j !== e.lat) begin
                failures++;
                $display("FAIL latency got=%0d want=%0d", j, e.lat);
            end
        end
        c0 = bus.out_class;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_class !== c0) begin
                failures++;
                $display("FAIL hold_stable valid=%b ready=%b class=%0d want 1/0/%0d",
                         bus.out_valid, bus.in_ready, bus.out_class, c0);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        int w;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_class !== '0 ||
            bus.out_depth !== '0 || bus.out_err !== 1'b0 || bus.cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state rdy=%b vld=%b cls=%0d dep=%0d err=%b cerr=%b want 1/0/0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.out_class, bus.out_depth,
                     bus.out_err, bus.cfg_err);
        end
        rst_n = 1'b1;
        push_exp(5'd0, 5'd0, 1'b0, 1);
        drive_vec(fv(8'h12, 8'h34, 8'h56), w);
        wait_result(0);
    endtask

    task automatic program_tree();
        cfg_write(5'd0, pack_node(1'b0, 3'd2, 3'd3, 8'd6, 5'd1, 5'd2));
        cfg_write(5'd1, pack_node(1'b1, 3'd0, 3'd0, 8'd19, 5'd0, 5'd0));
        cfg_write(5'd2, pack_node(1'b0, 3'd0, 3'd0, 8'd26, 5'd3, 5'd4));
        cfg_write(5'd3, pack_node(1'b1, 3'd0, 3'd0, 8'd25, 5'd0, 5'd0));
        cfg_write(5'd4, pack_node(1'b1, 3'd0, 3'd0, 8'd31, 5'd0, 5'd0));
    endtask

    task automatic test_tree_walk();
        int w;
        push_exp(5'd19, 5'd1, 1'b0, 2);
        drive_vec(fv(8'd0, 8'h30, 8'd0), w);
        wait_result(0);
        push_exp(5'd25, 5'd2, 1'b0, 3);
        drive_vec(fv(8'd26, 8'h38, 8'd0), w);
        wait_result(0);
        push_exp(5'd31, 5'd2, 1'b0, 3);
        drive_vec(fv(8'd27, 8'h38, 8'd0), w);
        wait_result(0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            sb.push_back(model(a, b));
            drive_vec(fv(a, b, 8'($urandom)), w);
            wait_result(i % 3);
        end
    endtask

    task automatic test_backpressure_back_to_back();
        int w;
        push_exp(5'd25, 5'd2, 1'b0, 3);
        drive_vec(fv(8'd5, 8'hF0, 8'd0), w);
        wait_result(5);
        push_exp(5'd19, 5'd1, 1'b0, 2);
        drive_vec(fv(8'd0, 8'h00, 8'd0), w);
        checks++;
        if (w !== 0) begin
            failures++;
            $display("FAIL back_to_back_accept got=%0d want=0", w);
        end
        wait_result(0);
    endtask

    task automatic test_watchdog();
        int w;
        cfg_write(5'd0, pack_node(1'b0, 3'd0, 3'd0, 8'd255, 5'd0, 5'd0));
        push_exp(5'd31, 5'd16, 1'b1, 17);
        drive_vec(fv(8'd1, 8'd2, 8'd3), w);
        wait_result(2);
        cfg_write(5'd0, pack_node(1'b0, 3'd2, 3'd3, 8'd6, 5'd1, 5'd2));
    endtask

    task automatic test_cfg_in_walk();
        int w;
        drive_vec(fv(8'd0, 8'h30, 8'd0), w);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = 5'd1;
        bus.cfg_wdata = pack_node(1'b1, 3'd0, 3'd0, 8'd5, 5'd0, 5'd0);
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL cfg_err_pulse got=%b want=1", bus.cfg_err);
        end
        @(negedge clk);
        checks++;
        if (bus.cfg_err !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_class !== 5'd19) begin
            failures++;
            $display("FAIL cfg_drop cerr=%b vld=%b cls=%0d want 0/1/19",
                     bus.cfg_err, bus.out_valid, bus.out_class);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_walk();
        int w;
        int seen;
        drive_vec(fv(8'd0, 8'h38, 8'd0), w);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abandoned_output got=%0d want=0", seen);
        end
        push_exp(5'd0, 5'd0, 1'b0, 1);
        drive_vec(fv(8'd0, 8'h30, 8'd0), w);
        wait_result(0);
    endtask

    task automatic test_feat_oob_shift();
        int w;
        cfg_write(5'd0, pack_node(1'b0, 3'd7, 3'd0, 8'd0, 5'd1, 5'd2));
        cfg_write(5'd1, pack_node(1'b0, 3'd3, 3'd7, 8'd0, 5'd3, 5'd4));
        cfg_write(5'd2, pack_node(1'b1, 3'd0, 3'd0, 8'd2, 5'd0, 5'd0));
        cfg_write(5'd3, pack_node(1'b1, 3'd0, 3'd0, 8'd3, 5'd0, 5'd0));
        cfg_write(5'd4, pack_node(1'b1, 3'd0, 3'd0, 8'd4, 5'd0, 5'd0));
        push_exp(5'd4, 5'd2, 1'b0, 3);
        drive_vec({(N_FEAT*FEAT_W){1'b1}}, w);
        wait_result(0);
        push_exp(5'd3, 5'd2, 1'b0, 3);
        drive_vec(fv(8'hFF, 8'hFF, 8'h7F), w);
        wait_result(0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_features = '0; bus.out_ready = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        test_reset();
        program_tree();
        test_tree_walk();
        test_backpressure_back_to_back();
        test_watchdog();
        test_cfg_in_walk();
        test_reset_mid_walk();
        test_feat_oob_shift();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
